// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: pixel coordinates, period measurement, lock qualification
module vga_sync_decoder #(
  parameter int H_TOTAL_EXP = 800,
  parameter int V_TOTAL_EXP = 525,
  parameter int TOL         = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       blank_n,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       pixel_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [3:0] LOCK_N     = LOCK_FRAMES[3:0];

  logic       hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] posx_q, posx_d, posy_q, posy_d;
  logic [9:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic       line_vis_q, line_vis_d;
  logic       h_ref_q, h_ref_d;
  logic       fbad_q, fbad_d;
  logic [3:0] good_q, good_d;
  logic [1:0] state_q, state_d;
  logic       locked_q, locked_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic       sync_err_q, sync_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       hs_rise, vs_rise, h_bad, v_bad, h_lost, err;
  logic [9:0] hcnt_inc, vcnt_inc, v_new;

  always_comb begin
    hs_rise  = h_sync & ~hs_q;
    vs_rise  = v_sync & ~vs_q;
    hcnt_inc = (hcnt_q == 10'h3FF) ? 10'h3FF : hcnt_q + 10'd1;
    vcnt_inc = (vcnt_q == 10'h3FF) ? 10'h3FF : vcnt_q + 10'd1;
    // A line closing on the same edge as the frame still belongs to the closing frame.
    v_new    = hs_rise ? vcnt_inc : vcnt_q;
    h_bad    = hs_rise && h_ref_q &&
               ((int'(hcnt_inc) > H_TOTAL_EXP + TOL) || (int'(hcnt_inc) < H_TOTAL_EXP - TOL));
    v_bad    = vs_rise &&
               ((int'(v_new) > V_TOTAL_EXP + TOL) || (int'(v_new) < V_TOTAL_EXP - TOL));
    h_lost   = !hs_rise && (hcnt_q == 10'h3FE);

    hs_d          = h_sync;
    vs_d          = v_sync;
    bl_d          = blank_n;
    line_start_d  = hs_rise;
    frame_start_d = vs_rise;
    hcnt_d        = hs_rise ? 10'd0 : hcnt_inc;
    h_meas_d      = hs_rise ? hcnt_inc : h_meas_q;
    // No line reference exists after reset or after h_sync was lost.
    h_ref_d       = hs_rise ? 1'b1 : (h_lost ? 1'b0 : h_ref_q);
    posx_d        = hs_rise ? 10'd0 : (bl_q ? posx_q + 10'd1 : posx_q);
    line_vis_d    = hs_rise ? 1'b0 : (line_vis_q | bl_q);
    posy_d        = vs_rise ? 10'd0 :
                    ((hs_rise && (line_vis_q | bl_q)) ? posy_q + 10'd1 : posy_q);
    vcnt_d        = vs_rise ? 10'd0 : (hs_rise ? vcnt_inc : vcnt_q);
    v_meas_d      = vs_rise ? v_new : v_meas_q;

    state_d  = state_q;
    good_d   = good_q;
    fbad_d   = fbad_q | h_bad;
    locked_d = locked_q;
    err      = 1'b0;

    if (h_lost) begin
      err      = (state_q != ST_SEARCH);
      state_d  = ST_SEARCH;
      locked_d = 1'b0;
      good_d   = 4'd0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (vs_rise) begin
            state_d = ST_MEASURE;
            good_d  = 4'd0;
            fbad_d  = 1'b0;
          end
        end
        ST_MEASURE: begin
          if (vs_rise) begin
            fbad_d = 1'b0;
            if (!fbad_q && !h_bad && !v_bad) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_N) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              err    = 1'b1;
              good_d = 4'd0;
            end
          end
        end
        ST_LOCKED: begin
          // The remainder of the frame after a dropout counts toward relock.
          if (h_bad || v_bad) begin
            err      = 1'b1;
            locked_d = 1'b0;
            state_d  = ST_MEASURE;
            good_d   = 4'd0;
            fbad_d   = 1'b0;
          end else if (vs_rise) begin
            fbad_d = 1'b0;
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          good_d   = 4'd0;
        end
      endcase
    end

    sync_err_d = err;
    err_cnt_d  = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      bl_q          <= 1'b0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      posx_q        <= 10'd0;
      posy_q        <= 10'd0;
      h_meas_q      <= 10'd0;
      v_meas_q      <= 10'd0;
      line_vis_q    <= 1'b0;
      h_ref_q       <= 1'b0;
      fbad_q        <= 1'b0;
      good_q        <= 4'd0;
      state_q       <= ST_SEARCH;
      locked_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      bl_q          <= bl_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      posx_q        <= posx_d;
      posy_q        <= posy_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      line_vis_q    <= line_vis_d;
      h_ref_q       <= h_ref_d;
      fbad_q        <= fbad_d;
      good_q        <= good_d;
      state_q       <= state_d;
      locked_q      <= locked_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign posx        = posx_q;
  assign posy        = posy_q;
  assign pixel_valid = bl_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a scaled-down 40x12 raster
module tb_vga_sync_decoder;
  logic       clk, rst, h_sync, v_sync, blank_n;
  logic [9:0] posx, posy, h_meas, v_meas;
  logic       pixel_valid, line_start, frame_start, locked, sync_err;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  // Raster: 40 clocks/line (h_sync 0..3, visible 10..33), 12 lines/frame (v_sync 0..1, visible 3..10)
  vga_sync_decoder #(.H_TOTAL_EXP(40), .V_TOTAL_EXP(12), .TOL(2), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n),
    .posx(posx), .posy(posy), .pixel_valid(pixel_valid), .line_start(line_start),
    .frame_start(frame_start), .h_meas(h_meas), .v_meas(v_meas), .locked(locked),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         ls_cnt, se_cnt, se_ls_idx, fs_cnt;
  logic [9:0] se_hmeas;
  logic       fs_locked [0:63];
  logic [9:0] fs_vmeas [0:63];
  logic [9:0] fs_hmeas [0:63];

  always @(negedge clk) begin
    if (line_start) ls_cnt++;
    if (sync_err) begin
      se_cnt++;
      if (line_start) begin
        se_ls_idx = ls_cnt;
        se_hmeas  = h_meas;
      end
    end
    if (frame_start) begin
      if (fs_cnt < 64) begin
        fs_locked[fs_cnt] = locked;
        fs_vmeas[fs_cnt]  = v_meas;
        fs_hmeas[fs_cnt]  = h_meas;
      end
      fs_cnt++;
    end
  end

  task automatic clear_mon();
    #1;
    ls_cnt = 0; se_cnt = 0; se_ls_idx = -1; fs_cnt = 0; se_hmeas = 10'd0;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic bl);
    h_sync = hs; v_sync = vs; blank_n = bl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int nlines, input int long_line, input int nrun);
    for (int l = 0; l < nrun; l++) begin
      int len;
      len = (l == long_line) ? 45 : 40;
      for (int c = 0; c < len; c++)
        drive(c < 4, l < 2, (l >= 3) && (l < 11) && (l < nlines) && (c >= 10) && (c < 34));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({posx, posy, h_meas, v_meas} !== 40'd0) begin
      n_fail++; $display("FAIL reset_counts: got %h expected 0", {posx, posy, h_meas, v_meas});
    end
    n_cmp++;
    if ({pixel_valid, line_start, frame_start, locked, sync_err, err_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %h expected 0", {pixel_valid, line_start, frame_start, locked, sync_err, err_cnt});
    end
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_nominal();
    clear_mon();
    repeat (3) run_frame(12, -1, 12);
    n_cmp++;
    if ({fs_locked[0], fs_locked[1], fs_locked[2]} !== 3'b001) begin
      n_fail++; $display("FAIL nominal_lock_seq: got %b expected 001", {fs_locked[0], fs_locked[1], fs_locked[2]});
    end
    n_cmp++;
    if (h_meas !== 10'd40) begin n_fail++; $display("FAIL nominal_h_meas: got %0d expected 40", h_meas); end
    n_cmp++;
    if (fs_vmeas[2] !== 10'd12) begin n_fail++; $display("FAIL nominal_v_meas: got %0d expected 12", fs_vmeas[2]); end
    n_cmp++;
    if (se_cnt !== 0) begin n_fail++; $display("FAIL nominal_no_err: got %0d expected 0", se_cnt); end
  endtask

  task automatic test_scan();
    for (int l = 0; l < 12; l++) begin
      for (int c = 0; c < 40; c++) begin
        logic bl;
        logic [9:0] ex, ey;
        bl = (l >= 3) && (l < 11) && (c >= 10) && (c < 34);
        ex = 10'(c - 10);
        ey = 10'(l - 3);
        drive(c < 4, l < 2, bl);
        n_cmp++;
        if (pixel_valid !== bl) begin
          n_fail++; $display("FAIL scan_pixel_valid l%0d c%0d: got %b expected %b", l, c, pixel_valid, bl);
        end
        if (bl) begin
          n_cmp++;
          if ({posx, posy} !== {ex, ey}) begin
            n_fail++; $display("FAIL scan_pos l%0d c%0d: got %0d,%0d expected %0d,%0d", l, c, posx, posy, ex, ey);
          end
        end
        if (c == 0) begin
          n_cmp++;
          if ({line_start, frame_start, posx} !== {1'b1, (l == 0), 10'd0}) begin
            n_fail++; $display("FAIL scan_line_start l%0d: got %b %b %0d expected 1 %b 0", l, line_start, frame_start, posx, (l == 0));
          end
        end
      end
    end
  endtask

  task automatic test_bad_line();
    clear_mon();
    run_frame(12, 5, 12);
    n_cmp++;
    if ({se_cnt, se_ls_idx} !== {32'd1, 32'd7}) begin
      n_fail++; $display("FAIL badline_err_at_line: got cnt %0d line %0d expected cnt 1 line 7", se_cnt, se_ls_idx);
    end
    n_cmp++;
    if (se_hmeas !== 10'd45) begin n_fail++; $display("FAIL badline_h_meas: got %0d expected 45", se_hmeas); end
    n_cmp++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL badline_unlocked: got %b expected 0", locked); end
    run_frame(12, -1, 12);
    run_frame(12, -1, 12);
    n_cmp++;
    if ({fs_locked[0], fs_locked[1], fs_locked[2]} !== 3'b101) begin
      n_fail++; $display("FAIL badline_relock: got %b expected 101", {fs_locked[0], fs_locked[1], fs_locked[2]});
    end
    n_cmp++;
    if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL badline_err_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_hsync_loss();
    int lost_at;
    lost_at = -1;
    clear_mon();
    n_cmp++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_pre_locked: got %b expected 1", locked); end
    // The last h_sync edge was 40 clocks before this loop, so hcnt hits 1023 at i=983.
    for (int i = 0; i < 1100; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (lost_at < 0 && locked !== 1'b1) begin
        lost_at = i;
        n_cmp++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL loss_err_pulse: got %b expected 1", sync_err); end
      end
    end
    n_cmp++;
    if (lost_at !== 983) begin n_fail++; $display("FAIL loss_cycle: got %0d expected 983", lost_at); end
    n_cmp++;
    if ({se_cnt, 24'd0, err_cnt} !== {32'd1, 32'd2}) begin
      n_fail++; $display("FAIL loss_err_count: got pulses %0d err_cnt %0d expected 1 2", se_cnt, err_cnt);
    end
    repeat (3) run_frame(12, -1, 12);
    n_cmp++;
    if (fs_hmeas[0] !== 10'd1023) begin n_fail++; $display("FAIL loss_h_meas_sat: got %0d expected 1023", fs_hmeas[0]); end
    n_cmp++;
    if ({fs_locked[0], fs_locked[1], fs_locked[2], se_cnt} !== {3'b001, 32'd1}) begin
      n_fail++; $display("FAIL loss_relock: got %b%b%b err %0d expected 001 err 1", fs_locked[0], fs_locked[1], fs_locked[2], se_cnt);
    end
  endtask

  task automatic test_v_tolerance();
    int lens [8];
    lens = '{7, 7, 7, 14, 14, 10, 15, 12};
    clear_mon();
    for (int f = 0; f < 8; f++) run_frame(lens[f], -1, lens[f]);
    n_cmp++;
    if ({fs_locked[0], fs_locked[1], fs_locked[2], fs_locked[3], fs_locked[4], fs_locked[5], fs_locked[6], fs_locked[7]} !== 8'b10000110) begin
      n_fail++;
      $display("FAIL vtol_lock_seq: got %b%b%b%b%b%b%b%b expected 10000110", fs_locked[0], fs_locked[1], fs_locked[2],
               fs_locked[3], fs_locked[4], fs_locked[5], fs_locked[6], fs_locked[7]);
    end
    n_cmp++;
    if ({fs_vmeas[1], fs_vmeas[4], fs_vmeas[6], fs_vmeas[7]} !== {10'd7, 10'd14, 10'd10, 10'd15}) begin
      n_fail++; $display("FAIL vtol_v_meas: got %0d %0d %0d %0d expected 7 14 10 15", fs_vmeas[1], fs_vmeas[4], fs_vmeas[6], fs_vmeas[7]);
    end
    n_cmp++;
    if ({se_cnt, 24'd0, err_cnt} !== {32'd4, 32'd6}) begin
      n_fail++; $display("FAIL vtol_errors: got pulses %0d err_cnt %0d expected 4 6", se_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    run_frame(12, -1, 12);
    run_frame(12, -1, 6);
    n_cmp++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_locked: got %b expected 1", locked); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({posx, posy, h_meas, v_meas, pixel_valid, line_start, frame_start, locked, sync_err, err_cnt} !== 53'd0) begin
      n_fail++; $display("FAIL midrst_async_clear: got %h expected 0",
                         {posx, posy, h_meas, v_meas, pixel_valid, line_start, frame_start, locked, sync_err, err_cnt});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    clear_mon();
    repeat (3) run_frame(12, -1, 12);
    n_cmp++;
    if ({fs_locked[0], fs_locked[1], fs_locked[2], err_cnt} !== {3'b001, 8'd0}) begin
      n_fail++; $display("FAIL midrst_relock: got %b%b%b err_cnt %0d expected 001 0", fs_locked[0], fs_locked[1], fs_locked[2], err_cnt);
    end
  endtask

  initial begin
    rst = 1'b0; h_sync = 1'b0; v_sync = 1'b0; blank_n = 1'b0;
    ls_cnt = 0; se_cnt = 0; se_ls_idx = -1; fs_cnt = 0; se_hmeas = 10'd0;
    test_reset();
    test_nominal();
    test_scan();
    test_bad_line();
    test_hsync_loss();
    test_v_tolerance();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
